// File: rtl/wide_add_seq_pkg.sv
// Shared types and default sizing for the word-serial wide adder.
// The FSM state enum is exported here so a bench can decode the debug state port.
package wide_add_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int DEF_ASIZE = 4;
   localparam int DEF_MAXW  = 8;

endpackage

// File: rtl/wide_add_seq_cla.sv
// Carry-lookahead block: produces every per-bit carry-out of one word directly
// from generate/propagate terms, with no rippling between bit positions.
module wide_add_seq_cla #(
   parameter int asize = 4
) (
   input  logic [asize-1:0] a,
   input  logic [asize-1:0] b,
   input  logic             cin,
   output logic [asize-1:0] carry
);

   logic [asize-1:0] g;
   logic [asize-1:0] p;

   assign g = a & b;
   assign p = a ^ b;

   // carry[i] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i]..p[0]cin
   always_comb begin
      logic c;
      logic pp;
      carry = '0;
      c     = 1'b0;
      pp    = 1'b0;
      for (int i = 0; i < asize; i++) begin
         c  = g[i];
         pp = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            c  = c | (pp & g[j]);
            pp = pp & p[j];
         end
         carry[i] = c | (pp & cin);
      end
   end

endmodule

// File: rtl/wide_add_seq.sv
// Word-serial wide adder: operands arrive least-significant word first and the
// carry is chained between words; one registered output stage with valid/ready.
module wide_add_seq
   import wide_add_seq_pkg::*;
#(
   parameter int asize = DEF_ASIZE,
   parameter int maxw  = DEF_MAXW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [asize-1:0] in_a,
   input  logic [asize-1:0] in_b,
   input  logic             in_first,
   input  logic             in_last,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [asize-1:0] out_sum,
   output logic             out_last,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_err,
   output state_e           state_dbg
);

   // Handshake: a word moves on a side when valid and ready are both high at
   // the rising edge; the output register may refill in the cycle it drains.

   localparam int            CW      = $clog2(maxw);
   localparam logic [CW-1:0] CNT_MAX = CW'(maxw - 1);

   state_e           state_q, state_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [asize-1:0] out_sum_q, out_sum_d;
   logic             out_last_q, out_last_d;
   logic             out_cout_q, out_cout_d;
   logic             out_ovf_q, out_ovf_d;
   logic             out_err_q, out_err_d;

   logic             accept;
   logic             start;
   logic             word_cin;
   logic [asize-1:0] carry;
   logic [asize-1:0] sum;
   logic [CW-1:0]    cur_idx;
   logic             force_last;
   logic             is_last;
   logic             proto_err;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // A word opens a packet when nothing is in flight or when it is flagged first.
   assign start     = (state_q == ST_IDLE) || in_first;
   assign proto_err = (state_q == ST_RUN) && in_first;
   assign word_cin  = start ? cin : carry_q;

   wide_add_seq_cla #(
      .asize(asize)
   ) u_cla (
      .a    (in_a),
      .b    (in_b),
      .cin  (word_cin),
      .carry(carry)
   );

   assign sum        = in_a ^ in_b ^ {carry[asize-2:0], word_cin};
   assign cur_idx    = start ? '0 : cnt_q;
   assign force_last = !in_last && (cur_idx == CNT_MAX);
   assign is_last    = in_last || force_last;

   always_comb begin
      state_d     = state_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_last_d  = out_last_q;
      out_cout_d  = out_cout_q;
      out_ovf_d   = out_ovf_q;
      out_err_d   = out_err_q;
      if (accept) begin
         state_d     = is_last ? ST_IDLE : ST_RUN;
         carry_d     = carry[asize-1];
         cnt_d       = is_last ? '0 : cur_idx + CW'(1);
         out_valid_d = 1'b1;
         out_sum_d   = sum;
         out_last_d  = is_last;
         out_cout_d  = is_last & carry[asize-1];
         out_ovf_d   = is_last & (carry[asize-1] ^ carry[asize-2]);
         out_err_d   = proto_err || force_last;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_last_q  <= 1'b0;
         out_cout_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_last_q  <= out_last_d;
         out_cout_q  <= out_cout_d;
         out_ovf_q   <= out_ovf_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_last  = out_last_q;
   assign out_cout  = out_cout_q;
   assign out_ovf   = out_ovf_q;
   assign out_err   = out_err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq: stimulus pushes hand-computed results into
// a queue and an independent monitor pops and compares each delivered word.
module tb_wide_add_seq;
   import wide_add_seq_pkg::*;

   localparam int ASIZE = 4;
   localparam int MAXW  = 8;
   localparam int W     = ASIZE + 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [ASIZE-1:0] in_a;
   logic [ASIZE-1:0] in_b;
   logic             in_first;
   logic             in_last;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [ASIZE-1:0] out_sum;
   logic             out_last;
   logic             out_cout;
   logic             out_ovf;
   logic             out_err;
   state_e           state_dbg;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] act_v;
   logic [W-1:0] exp_v;

   wide_add_seq #(
      .asize(ASIZE),
      .maxw (MAXW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_first (in_first),
      .in_last  (in_last),
      .cin      (cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_last (out_last),
      .out_cout (out_cout),
      .out_ovf  (out_ovf),
      .out_err  (out_err),
      .state_dbg(state_dbg)
   );

   // clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // driver: present one word, wait for acceptance, record the expected result
   task automatic send(input logic [ASIZE-1:0] a, input logic [ASIZE-1:0] b,
                       input logic first, input logic last, input logic c,
                       input logic [ASIZE-1:0] esum, input logic elast,
                       input logic ecout, input logic eovf, input logic eerr);
      int n;
      in_a     = a;
      in_b     = b;
      in_first = first;
      in_last  = last;
      cin      = c;
      in_valid = 1'b1;
      n        = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
      end else begin
         @(posedge clk);
         exp_q.push_back({eerr, eovf, ecout, elast, esum});
      end
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         act_v = {out_err, out_ovf, out_cout, out_last, out_sum};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_word: got 0x%0h with no word expected", act_v);
         end else begin
            exp_v = exp_q.pop_front();
            if (act_v !== exp_v) begin
               failures++;
               $display("FAIL out_word: got err=%0b ovf=%0b cout=%0b last=%0b sum=%0h expected err=%0b ovf=%0b cout=%0b last=%0b sum=%0h",
                        act_v[7], act_v[6], act_v[5], act_v[4], act_v[3:0],
                        exp_v[7], exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
            end
         end
      end
   end

   initial begin
      int n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      cin       = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_sum", 32'(out_sum), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_out_cout", 32'(out_cout), 0);
      check("rst_out_ovf", 32'(out_ovf), 0);
      check("rst_out_err", 32'(out_err), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      @(posedge clk);
      #1;

      // 0x1234 + 0x0FFF; cin=1 on later words must be ignored
      send(4'h4, 4'hF, 1, 0, 0, 4'h3, 0, 0, 0, 0);
      send(4'h3, 4'hF, 0, 0, 1, 4'h3, 0, 0, 0, 0);
      send(4'h2, 4'hF, 0, 0, 1, 4'h2, 0, 0, 0, 0);
      send(4'h1, 4'h0, 0, 1, 1, 4'h2, 1, 0, 0, 0);

      // 0xFFFF + 0x0001
      send(4'hF, 4'h1, 1, 0, 0, 4'h0, 0, 0, 0, 0);
      send(4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
      send(4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
      send(4'hF, 4'h0, 0, 1, 0, 4'h0, 1, 1, 0, 0);

      // 0x7FFF + 0x0001, then one-word packets
      send(4'hF, 4'h1, 1, 0, 0, 4'h0, 0, 0, 0, 0);
      send(4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
      send(4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
      send(4'h7, 4'h0, 0, 1, 0, 4'h8, 1, 0, 1, 0);
      send(4'h7, 4'h1, 1, 1, 0, 4'h8, 1, 0, 1, 0);
      send(4'h5, 4'h9, 1, 1, 1, 4'hF, 1, 0, 0, 0);

      // stall for 3 cycles mid-packet with the next word already offered
      send(4'h4, 4'hF, 1, 0, 0, 4'h3, 0, 0, 0, 0);
      send(4'h3, 4'hF, 0, 0, 0, 4'h3, 0, 0, 0, 0);
      out_ready = 1'b0;
      in_a      = 4'h2;
      in_b      = 4'hF;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 0);
         check("stall_out_valid", 32'(out_valid), 1);
         check("stall_out_sum", 32'(out_sum), 32'h3);
         check("stall_out_last", 32'(out_last), 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(4'h2, 4'hF, 0, 0, 0, 4'h2, 0, 0, 0, 0);
      send(4'h1, 4'h0, 0, 1, 0, 4'h2, 1, 0, 0, 0);

      // reset after word 2 of 4 with carry=1, a word offered during reset
      send(4'hF, 4'h1, 1, 0, 0, 4'h0, 0, 0, 0, 0);
      send(4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      rst      = 1'b1;
      in_a     = 4'h5;
      in_b     = 4'h5;
      in_first = 1'b1;
      in_last  = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      check("post_rst_out_valid", 32'(out_valid), 0);
      check("post_rst_state", 32'(state_dbg), 32'(ST_IDLE));
      check("post_rst_in_ready", 32'(in_ready), 1);
      check("post_rst_queue", 32'(exp_q.size()), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      send(4'h1, 4'h1, 0, 1, 0, 4'h2, 1, 0, 0, 0);

      // in_first on word 3 restarts the packet with cin and flags an error
      send(4'h1, 4'h1, 1, 0, 0, 4'h2, 0, 0, 0, 0);
      send(4'h8, 4'h8, 0, 0, 0, 4'h0, 0, 0, 0, 0);
      send(4'h3, 4'h3, 1, 0, 0, 4'h6, 0, 0, 0, 1);
      send(4'h4, 4'h4, 0, 1, 0, 4'h8, 1, 0, 1, 0);

      // maxw words without in_last: the last one is forced, then IDLE uses cin
      for (int k = 0; k < MAXW; k++) begin
         send(4'h1, 4'h0, (k == 0), 0, 0, 4'h1, (k == MAXW - 1), 0, 0, (k == MAXW - 1));
      end
      send(4'h2, 4'h3, 0, 1, 1, 4'h6, 1, 0, 0, 0);

      // drain
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         n++;
         @(negedge clk);
      end
      @(negedge clk);
      check("drain_queue_empty", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
